// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// The reset-time pattern and length defaults live here so that every user agrees on them.
package seq_detect_pkg;

  localparam int          PAT_W_DEF = 8;
  localparam int          CNT_W_DEF = 16;
  localparam logic [31:0] DEF_PAT_C = 32'b101;
  localparam int          DEF_LEN_C = 3;

  // Width needed to hold a pattern length from 0 up to pat_w inclusive.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked comparator: flags when the low len_i bits of the candidate history equal
// the low len_i bits of the pattern. Bits at or above len_i are ignored.
module seq_match_cmp
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic [PAT_W-1:0]        hist_n_i,
  input  logic [PAT_W-1:0]        pat_i,
  input  logic [len_w(PAT_W)-1:0] len_i,
  output logic                    match_o
);

  logic [PAT_W-1:0] mask_s;

  // Thermometer mask with one bit set per active pattern position.
  always_comb begin
    mask_s = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask_s[i] = (32'(len_i) > i);
    end
  end

  assign match_o = (((hist_n_i ^ pat_i) & mask_s) == '0);

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with runtime pattern/length/overlap selection.
// Optional saturating match counter is built only when SEQ_DETECT_COUNT_EN is defined.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_C),
  parameter int               DEF_LEN = DEF_LEN_C
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    x,
  input  logic                    x_valid,
  input  logic                    cfg_load,
  input  logic [PAT_W-1:0]        cfg_pat,
  input  logic [len_w(PAT_W)-1:0] cfg_len,
  input  logic                    cfg_overlap,
  input  logic                    clear,
  output logic                    z,
  output logic [CNT_W-1:0]        match_count,
  output logic                    cfg_err
);

  localparam int LEN_W = len_w(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic             z_q, z_d;
  logic             err_q, err_d;

  logic [PAT_W-1:0] hist_n_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic             cmp_match_s;
  logic             cfg_ok_s;
  logic             sample_take_s;
  logic             match_take_s;

  assign hist_n_s      = {hist_q[PAT_W-2:0], x};
  assign fill_inc_s    = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
  assign cfg_ok_s      = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign sample_take_s = x_valid && !cfg_load && !clear;
  assign match_take_s  = sample_take_s && cmp_match_s && (fill_inc_s >= len_q);

  seq_match_cmp #(
    .PAT_W (PAT_W)
  ) u_cmp (
    .hist_n_i (hist_n_s),
    .pat_i    (pat_q),
    .len_i    (len_q),
    .match_o  (cmp_match_s)
  );

  // Next-state: clear beats cfg_load beats sampling; a colliding bit is dropped.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    z_d    = 1'b0;
    err_d  = 1'b0;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
      if (cfg_load && cfg_ok_s) begin
        pat_d = cfg_pat;
        len_d = cfg_len;
        ovl_d = cfg_overlap;
      end else begin
        err_d = cfg_load;
      end
    end else if (cfg_load) begin
      if (cfg_ok_s) begin
        pat_d  = cfg_pat;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        hist_d = '0;
        fill_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (x_valid) begin
      hist_d = hist_n_s;
      // Non-overlapping mode restarts the window so matched bits are not reused.
      fill_d = (match_take_s && !ovl_q) ? '0 : fill_inc_s;
      z_d    = match_take_s;
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PAT;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= 1'b1;
      z_q    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      z_q    <= z_d;
      err_q  <= err_d;
    end
  end

  assign z       = z_q;
  assign cfg_err = err_q;

`ifdef SEQ_DETECT_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter; it moves on the same edge that raises z.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (match_take_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial pattern detector. It is the parametrised successor of the fixed "101" detector. It samples one serial bit per qualified clock and compares the most recent bits against a runtime-loaded pattern of 1..PAT_W bits. It pulses `z` on each match and keeps a saturating match count. Overlapping and non-overlapping detection are selectable at runtime. It sits on the serial input path and drives match flags to the control logic.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 16: match counter width.
- `DEF_PAT`, 'b101: pattern value loaded at reset.
- `DEF_LEN`, 3: pattern length loaded at reset (1..PAT_W).
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `x` in 1: serial data bit.
- `x_valid` in 1: `x` is sampled only when this is high.
- `cfg_load` in 1: one-cycle strobe that latches `cfg_pat`, `cfg_len` and `cfg_overlap`.
- `cfg_pat` in PAT_W: pattern. Bit `[cfg_len-1]` is the first bit received; bit 0 is the last.
- `cfg_len` in $clog2(PAT_W+1): pattern length.
- `cfg_overlap` in 1: 1 = overlapping detection, 0 = non-overlapping.
- `clear` in 1: synchronous flush of history and match count; configuration is kept.
- `z` out 1: registered one-cycle match pulse.
- `match_count` out CNT_W: saturating number of matches.
- `cfg_err` out 1: registered one-cycle pulse on a rejected `cfg_load`.

## Operation
- **Registers:** history shift register `hist[PAT_W-1:0]`; fill counter `fill` (0..PAT_W, saturates at PAT_W); active configuration `pat`, `len`, `ovl`.
- **Sample** (`x_valid`=1, no `cfg_load`, no `clear`):
  - `hist_n = {hist[PAT_W-2:0], x}`, `fill_n = min(fill+1, PAT_W)`.
  - Match when `fill_n ≥ len` and the low `len` bits of `hist_n` equal the low `len` bits of `pat`. Mask bits `≥ len` are ignored.
  - On a match: `z` is 1 next cycle and `match_count` increments, holding at 2^CNT_W−1.
  - On a match with `ovl`=0: `fill` is set to 0 instead of `fill_n`, so no bit of a matched window is reused.
- **Idle** (`x_valid`=0): history, fill and count hold; `z`=0.
- **Config load:** a `cfg_load` with `1 ≤ cfg_len ≤ PAT_W` latches the new configuration, sets `fill`=0 and `hist`=0, and leaves the count unchanged.
  - Otherwise the configuration is unchanged and `cfg_err`=1 for one cycle; history, fill and count are untouched.
- **Clear:** `clear` sets `hist`=0, `fill`=0, `match_count`=0 and `z`=0 next cycle.
- **Priority on the same edge:** `clear` > `cfg_load` > sample.
  - `cfg_load` plus `x_valid`: the bit is discarded.
  - `clear` plus a valid `cfg_load`: both take effect.
  - `clear` plus `x_valid`: the bit is discarded.

## Timing
- **Reset values:** `z`=0, `match_count`=0, `cfg_err`=0, `hist`=0, `fill`=0, `pat`=DEF_PAT, `len`=DEF_LEN, `ovl`=1.
- **Latency:** `z` is high during the cycle after the edge that samples the completing bit.
- **Counter timing:** `match_count` updates on the same edge that raises `z`.
- **Back-to-back matches:** with `ovl`=1 and `len`=1, `z` can be high on consecutive cycles.
- **Reset mid-stream:** partial history is lost; the next match needs `len` fresh bits.
- **Counter saturation:** `match_count` holds at its maximum, and `z` still pulses.

## Configuration
- `SEQ_DETECT_COUNT_EN` defined: the match counter is implemented as described.
- Undefined:
  - no counter registers are built and `match_count` is tied to 0;
  - `clear` still flushes history and fill;
  - `z` behaviour is identical.

## Structure
- Shared package `seq_detect_pkg`: the `PAT_W`/`CNT_W` defaults, the length-width function (`$clog2(PAT_W+1)`), and the reset-default constants `DEF_PAT`/`DEF_LEN`.
- One sub-module, `seq_match_cmp`: a combinational masked comparator taking `hist_n`, `pat` and `len` and returning the match flag.
- The top level holds the history register, fill counter, configuration registers and counter.

## Test plan
- **Default 101, overlap:** after reset, `x` = 1,0,1,0,1 → `z` pulses after bits 3 and 5; `match_count`=2.
- **Non-overlap:** load `len`=3, `pat`='b101, `ovl`=0; `x` = 1,0,1,0,1 → one `z` pulse after bit 3 only; `match_count`=1.
- **Long pattern:** load `len`=4, `pat`='b1101, `ovl`=1; `x` = 1,1,0,1,1,0,1 → `z` after bits 4 and 7.
  - Insert `x_valid`=0 gaps → same pulses, shifted by the gaps.
- **Bad config:** `cfg_load` with `cfg_len`=0, then `cfg_len`=PAT_W+1 → `cfg_err` pulses each time; the 101 pattern is still detected afterward.
- **Reset / clear / collision:**
  - `x` = 1,0, then `reset` low, then `x`=1 → no `z`.
  - `clear` together with `x_valid` → bit discarded, count 0.
  - `cfg_load` together with `x_valid` → bit discarded, `fill`=0.
- **Saturation and macro:**
  - `CNT_W`=2, five matches → `match_count`=3 and `z` pulses 5 times.
  - Without `SEQ_DETECT_COUNT_EN` → `match_count` is constantly 0.
